rl_step_sequencer: RTL and testbench
====================================

# rl_step_sequencer

Step-level controller for the two-agent reward datapath in the Q-learning core. Joins the per-step action handshakes from Agent A and Agent B, fires one capture strobe into the shared reward decider, waits out its fixed pipeline latency, then holds reward-valid to each agent until that agent acknowledges its Q-update. Counts steps and episodes and ends an episode on an environment terminal flag or a step limit.

## Interface
- RD_LAT, 2: reward-decider latency in cycles, from the capture strobe to a valid R_A/R_B; legal range 1..15
- STEP_W, 16: step counter width
- EP_W, 16: episode counter width
- MAX_STEPS, 1000: step limit per episode; must be ≥1 and < 2^STEP_W
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins an episode when idle
- terminal  input  1  environment terminal flag, sampled in COMMIT
- act_valid_A / act_valid_B  input  1  agent has its action (A, Amax, Amin) on the bus
- act_ready_A / act_ready_B  output  1  sequencer accepts that agent's action
- rd_issue  output  1  one-cycle capture enable into the reward decider
- rew_valid_A / rew_valid_B  output  1  R_A / R_B is valid; held until acknowledged
- upd_done_A / upd_done_B  input  1  agent finished its Q-update for this step
- step_cnt  output  STEP_W  steps completed in the current or last episode
- ep_cnt  output  EP_W  episodes completed; wraps modulo 2^EP_W
- busy  output  1  high in every state except IDLE
- episode_done  output  1  one-cycle pulse at episode end

## Operation
- States: IDLE, COLLECT, ISSUE, WAIT, REWARD, COMMIT.
- IDLE: when start=1, clear step_cnt, clear the got_A/got_B and done_A/done_B flags, then go to COLLECT. In every other state, start is ignored.
- COLLECT: act_ready_X = !got_X. A transfer happens when act_valid_X & act_ready_X; it sets got_X. When both got flags are set, or both transfers happen in the same cycle, go to ISSUE.
- ISSUE: rd_issue=1 for exactly one cycle; load the latency counter with RD_LAT; go to WAIT.
- WAIT: decrement the counter each cycle; at the cycle the counter reads 1, go to REWARD.
- REWARD: rew_valid_X = !done_X. Seeing upd_done_X while rew_valid_X=1 sets done_X. upd_done_X in any other state or cycle is ignored. When both done flags are set, go to COMMIT.
- COMMIT: step_cnt += 1. If terminal=1 or the new step_cnt == MAX_STEPS: pulse episode_done, ep_cnt += 1, go to IDLE. Otherwise clear the got/done flags and go to COLLECT.
- terminal and the step limit in the same COMMIT produce a single episode_done and a single ep_cnt increment.
- step_cnt holds its final value in IDLE until the next accepted start.

## Timing
- Reset values: all outputs 0, state IDLE, all flags 0, counters 0. Assertion of rst mid-step aborts the step immediately; no rd_issue, rew_valid or episode_done is emitted afterward.
- act_ready_X falls in the cycle after its transfer.
- rd_issue at cycle t. WAIT occupies t+1..t+RD_LAT. rew_valid_A/B rise at t+RD_LAT+1.
- rew_valid_X falls in the cycle after upd_done_X is sampled high.
- COMMIT lasts one cycle. The next COLLECT, with act_ready high, begins the following cycle.
- Minimum step length: 1 (COLLECT) + 1 (ISSUE) + RD_LAT + 1 (REWARD) + 1 (COMMIT) cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from input to output.

## Structure
- Shared package: state enum, default RD_LAT, default STEP_W/EP_W widths.
- Sub-module rl_lat_timer: loadable 4-bit down-counter with a done flag, used in WAIT.

## Test plan
- Reset, then start; both act_valid high together → both transfers in one cycle, rd_issue one cycle later, rew_valid_A/B exactly RD_LAT+1 cycles after rd_issue.
- act_valid_A at cycle 3, act_valid_B at cycle 9 → act_ready_A low from cycle 4, a single rd_issue after cycle 9, never two.
- upd_done_B 5 cycles before upd_done_A → rew_valid_B drops first, rew_valid_A stays high, COMMIT only after upd_done_A; a stray upd_done_A pulsed during WAIT has no effect.
- MAX_STEPS=3, terminal=0 → episode_done after step 3, step_cnt=3, ep_cnt=1, busy=0; terminal=1 asserted in step 2 of the next episode → episode_done with step_cnt=2, ep_cnt=2.
- rst pulled low during WAIT → all outputs 0 asynchronously, no rew_valid after release; a new start runs a clean step with step_cnt counting from 0.
- start pulsed while busy → ignored: step_cnt not cleared, no state change.

Source files
------------

// File: rtl/rl_step_sequencer_pkg.sv
// Shared types and defaults for the Q-learning step sequencer.
package rl_step_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_REWARD  = 3'd4,
        ST_COMMIT  = 3'd5
    } state_e;

    localparam int RD_LAT_DEF = 2;
    localparam int STEP_W_DEF = 16;
    localparam int EP_W_DEF   = 16;
    localparam int LAT_W      = 4;

endpackage

// File: rtl/rl_step_sequencer_lat_timer.sv
// Loadable down-counter that times the reward-decider pipeline latency.
module rl_lat_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // The last waiting cycle is the one in which the counter reads 1.
    assign done = (count_q == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rl_step_sequencer.sv
// Step-level controller: joins both agents' actions, strobes the reward
// decider, waits out its latency, then holds reward-valid until each agent acks.
module rl_step_sequencer
    import rl_step_sequencer_pkg::*;
#(
    parameter int RD_LAT    = RD_LAT_DEF,
    parameter int STEP_W    = STEP_W_DEF,
    parameter int EP_W      = EP_W_DEF,
    parameter int MAX_STEPS = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              terminal,
    input  logic              act_valid_A,
    input  logic              act_valid_B,
    output logic              act_ready_A,
    output logic              act_ready_B,
    output logic              rd_issue,
    output logic              rew_valid_A,
    output logic              rew_valid_B,
    input  logic              upd_done_A,
    input  logic              upd_done_B,
    output logic [STEP_W-1:0] step_cnt,
    output logic [EP_W-1:0]   ep_cnt,
    output logic              busy,
    output logic              episode_done
);

    localparam logic [STEP_W-1:0] MAX_STEPS_C = STEP_W'(MAX_STEPS);
    localparam logic [LAT_W-1:0]  RD_LAT_C    = LAT_W'(RD_LAT);

    state_e            state_q, state_d;
    logic              got_a_q, got_a_d;
    logic              got_b_q, got_b_d;
    logic              done_a_q, done_a_d;
    logic              done_b_q, done_b_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [EP_W-1:0]   ep_cnt_q, ep_cnt_d;
    logic              episode_done_q, episode_done_d;
    logic [STEP_W-1:0] step_next_s;
    logic              tmr_load_s;
    logic              tmr_dec_s;
    logic              tmr_done_s;
    logic              xfer_a_s;
    logic              xfer_b_s;

    rl_lat_timer #(
        .W (LAT_W)
    ) u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_s),
        .load_val (RD_LAT_C),
        .dec      (tmr_dec_s),
        .done     (tmr_done_s)
    );

    assign act_ready_A  = (state_q == ST_COLLECT) && !got_a_q;
    assign act_ready_B  = (state_q == ST_COLLECT) && !got_b_q;
    assign rd_issue     = (state_q == ST_ISSUE);
    assign rew_valid_A  = (state_q == ST_REWARD) && !done_a_q;
    assign rew_valid_B  = (state_q == ST_REWARD) && !done_b_q;
    assign busy         = (state_q != ST_IDLE);
    assign step_cnt     = step_cnt_q;
    assign ep_cnt       = ep_cnt_q;
    assign episode_done = episode_done_q;

    assign xfer_a_s = act_valid_A && act_ready_A;
    assign xfer_b_s = act_valid_B && act_ready_B;

    // Next-state, flag and counter logic for the step FSM.
    always_comb begin
        state_d        = state_q;
        got_a_d        = got_a_q;
        got_b_d        = got_b_q;
        done_a_d       = done_a_q;
        done_b_d       = done_b_q;
        step_cnt_d     = step_cnt_q;
        ep_cnt_d       = ep_cnt_q;
        episode_done_d = 1'b0;
        tmr_load_s     = 1'b0;
        tmr_dec_s      = 1'b0;
        step_next_s    = step_cnt_q + {{(STEP_W-1){1'b0}}, 1'b1};
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    step_cnt_d = {STEP_W{1'b0}};
                    got_a_d    = 1'b0;
                    got_b_d    = 1'b0;
                    done_a_d   = 1'b0;
                    done_b_d   = 1'b0;
                    state_d    = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (xfer_a_s) begin
                    got_a_d = 1'b1;
                end else begin
                    got_a_d = got_a_q;
                end
                if (xfer_b_s) begin
                    got_b_d = 1'b1;
                end else begin
                    got_b_d = got_b_q;
                end
                // Using the _d flags covers both transfers landing in one cycle.
                if (got_a_d && got_b_d) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_ISSUE: begin
                tmr_load_s = 1'b1;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_dec_s = 1'b1;
                if (tmr_done_s) begin
                    state_d = ST_REWARD;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_REWARD: begin
                if (upd_done_A && rew_valid_A) begin
                    done_a_d = 1'b1;
                end else begin
                    done_a_d = done_a_q;
                end
                if (upd_done_B && rew_valid_B) begin
                    done_b_d = 1'b1;
                end else begin
                    done_b_d = done_b_q;
                end
                if (done_a_d && done_b_d) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_REWARD;
                end
            end
            ST_COMMIT: begin
                step_cnt_d = step_next_s;
                if (terminal || (step_next_s == MAX_STEPS_C)) begin
                    episode_done_d = 1'b1;
                    ep_cnt_d       = ep_cnt_q + {{(EP_W-1){1'b0}}, 1'b1};
                    state_d        = ST_IDLE;
                end else begin
                    got_a_d  = 1'b0;
                    got_b_d  = 1'b0;
                    done_a_d = 1'b0;
                    done_b_d = 1'b0;
                    state_d  = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, flag and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            got_a_q        <= 1'b0;
            got_b_q        <= 1'b0;
            done_a_q       <= 1'b0;
            done_b_q       <= 1'b0;
            step_cnt_q     <= {STEP_W{1'b0}};
            ep_cnt_q       <= {EP_W{1'b0}};
            episode_done_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            got_a_q        <= got_a_d;
            got_b_q        <= got_b_d;
            done_a_q       <= done_a_d;
            done_b_q       <= done_b_d;
            step_cnt_q     <= step_cnt_d;
            ep_cnt_q       <= ep_cnt_d;
            episode_done_q <= episode_done_d;
        end
    end

endmodule

// File: tb/tb_rl_step_sequencer.sv
// Randomized self-checking bench for rl_step_sequencer; expected behaviour is
// derived from event times (transfer, issue, reward, commit) of each step.
module tb_rl_step_sequencer;

    localparam int RD_LAT    = 3;
    localparam int STEP_W    = 16;
    localparam int EP_W      = 16;
    localparam int MAX_STEPS = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              terminal;
    logic              act_valid_A;
    logic              act_valid_B;
    logic              act_ready_A;
    logic              act_ready_B;
    logic              rd_issue;
    logic              rew_valid_A;
    logic              rew_valid_B;
    logic              upd_done_A;
    logic              upd_done_B;
    logic [STEP_W-1:0] step_cnt;
    logic [EP_W-1:0]   ep_cnt;
    logic              busy;
    logic              episode_done;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_step = 0;
    int exp_ep   = 0;

    rl_step_sequencer #(
        .RD_LAT    (RD_LAT),
        .STEP_W    (STEP_W),
        .EP_W      (EP_W),
        .MAX_STEPS (MAX_STEPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .terminal     (terminal),
        .act_valid_A  (act_valid_A),
        .act_valid_B  (act_valid_B),
        .act_ready_A  (act_ready_A),
        .act_ready_B  (act_ready_B),
        .rd_issue     (rd_issue),
        .rew_valid_A  (rew_valid_A),
        .rew_valid_B  (rew_valid_B),
        .upd_done_A   (upd_done_A),
        .upd_done_B   (upd_done_B),
        .step_cnt     (step_cnt),
        .ep_cnt       (ep_cnt),
        .busy         (busy),
        .episode_done (episode_done)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        start       = 1'b0;
        terminal    = 1'b0;
        act_valid_A = 1'b0;
        act_valid_B = 1'b0;
        upd_done_A  = 1'b0;
        upd_done_B  = 1'b0;
    endtask

    // One step, starting at the first COLLECT cycle. Agent X presents its
    // action from cycle vX and acks its reward uX cycles after rewards open.
    task automatic run_step(input int va, input int vb, input int ua, input int ub,
                            input bit term, input bit stray, input bit sbusy,
                            output bit ended);
        int m, r0, cm;
        m  = (va > vb) ? va : vb;
        r0 = m + 2 + RD_LAT;
        cm = r0 + ((ua > ub) ? ua : ub) + 1;
        for (int c = 0; c <= cm; c++) begin
            @(negedge clk);
            n_checks += 8;
            if (act_ready_A !== ((c <= m) && (c <= va))) begin
                n_fail++; $display("FAIL act_ready_A c=%0d got %b want %b", c, act_ready_A, (c <= m) && (c <= va));
            end
            if (act_ready_B !== ((c <= m) && (c <= vb))) begin
                n_fail++; $display("FAIL act_ready_B c=%0d got %b want %b", c, act_ready_B, (c <= m) && (c <= vb));
            end
            if (rd_issue !== (c == m + 1)) begin
                n_fail++; $display("FAIL rd_issue c=%0d got %b want %b", c, rd_issue, c == m + 1);
            end
            if (rew_valid_A !== ((c >= r0) && (c <= r0 + ua))) begin
                n_fail++; $display("FAIL rew_valid_A c=%0d got %b want %b", c, rew_valid_A, (c >= r0) && (c <= r0 + ua));
            end
            if (rew_valid_B !== ((c >= r0) && (c <= r0 + ub))) begin
                n_fail++; $display("FAIL rew_valid_B c=%0d got %b want %b", c, rew_valid_B, (c >= r0) && (c <= r0 + ub));
            end
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL busy_in_step c=%0d got %b want 1", c, busy);
            end
            if (episode_done !== 1'b0) begin
                n_fail++; $display("FAIL episode_done_in_step c=%0d got %b want 0", c, episode_done);
            end
            if (step_cnt !== 16'(exp_step) || ep_cnt !== 16'(exp_ep)) begin
                n_fail++; $display("FAIL counters_in_step c=%0d got %0d/%0d want %0d/%0d", c, step_cnt, ep_cnt, exp_step, exp_ep);
            end
            start       = sbusy && (c == m + 1);
            act_valid_A = (c >= va) && (c <= m);
            act_valid_B = (c >= vb) && (c <= m);
            upd_done_A  = (c == r0 + ua) || (stray && (c < r0) && ($urandom_range(0, 1) == 1));
            upd_done_B  = (c == r0 + ub) || (stray && (c < r0) && ($urandom_range(0, 1) == 1));
            terminal    = (c == cm) ? term : ($urandom_range(0, 1) == 1);
        end
        exp_step++;
        ended = term || (exp_step == MAX_STEPS);
        if (ended) exp_ep = (exp_ep + 1) % (1 << EP_W);
    endtask

    task automatic begin_episode();
        start    = 1'b1;
        exp_step = 0;
    endtask

    task automatic check_episode_end();
        @(negedge clk);
        idle_inputs();
        n_checks += 3;
        if (episode_done !== 1'b1) begin
            n_fail++; $display("FAIL episode_done_pulse got %b want 1", episode_done);
        end
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL busy_at_end got %b want 0", busy);
        end
        if (step_cnt !== 16'(exp_step) || ep_cnt !== 16'(exp_ep)) begin
            n_fail++; $display("FAIL counters_at_end got %0d/%0d want %0d/%0d", step_cnt, ep_cnt, exp_step, exp_ep);
        end
        act_valid_A = 1'b1;
        upd_done_B  = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks += 2;
            if (episode_done !== 1'b0 || busy !== 1'b0 || act_ready_A !== 1'b0 || rew_valid_B !== 1'b0) begin
                n_fail++; $display("FAIL idle_quiet got done=%b busy=%b rdyA=%b rewB=%b want 0", episode_done, busy, act_ready_A, rew_valid_B);
            end
            if (step_cnt !== 16'(exp_step)) begin
                n_fail++; $display("FAIL step_cnt_hold got %0d want %0d", step_cnt, exp_step);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #1;
        @(negedge clk);
        n_checks++;
        if ({act_ready_A, act_ready_B, rd_issue, rew_valid_A, rew_valid_B, busy, episode_done} !== 7'd0
            || step_cnt !== 16'd0 || ep_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_outputs got rdy=%b%b iss=%b rew=%b%b busy=%b ed=%b sc=%0d ec=%0d want all 0",
                act_ready_A, act_ready_B, rd_issue, rew_valid_A, rew_valid_B, busy, episode_done, step_cnt, ep_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset busy got %b want 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        bit e;
        begin_episode();
        run_step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic test_staggered();
        bit e;
        run_step(3, 9, 1, 2, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic test_reward_order();
        bit e;
        run_step(1, 0, 5, 0, 1'b0, 1'b1, 1'b0, e);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL model_limit_reached got %b want 1", e);
        end
        check_episode_end();
    endtask

    task automatic test_terminal();
        bit e;
        begin_episode();
        run_step(2, 1, 0, 3, 1'b0, 1'b1, 1'b0, e);
        run_step(0, 4, 2, 2, 1'b1, 1'b0, 1'b1, e);
        check_episode_end();
    endtask

    task automatic test_term_and_limit();
        bit e;
        begin_episode();
        run_step(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, e);
        run_step(1, 1, 1, 0, 1'b0, 1'b0, 1'b0, e);
        run_step(0, 2, 0, 1, 1'b1, 1'b0, 1'b0, e);
        check_episode_end();
    endtask

    task automatic test_reset_mid_wait();
        bit e;
        begin_episode();
        @(negedge clk);
        start       = 1'b0;
        act_valid_A = 1'b1;
        act_valid_B = 1'b1;
        @(negedge clk);
        act_valid_A = 1'b0;
        act_valid_B = 1'b0;
        n_checks++;
        if (rd_issue !== 1'b1) begin
            n_fail++; $display("FAIL rd_issue_before_reset got %b want 1", rd_issue);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        exp_ep   = 0;
        exp_step = 0;
        n_checks++;
        if ({act_ready_A, act_ready_B, rd_issue, rew_valid_A, rew_valid_B, busy, episode_done} !== 7'd0
            || step_cnt !== 16'd0 || ep_cnt !== 16'd0) begin
            n_fail++; $display("FAIL async_reset_outputs got iss=%b rew=%b%b busy=%b sc=%0d ec=%0d want all 0",
                rd_issue, rew_valid_A, rew_valid_B, busy, step_cnt, ep_cnt);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            upd_done_A = ($urandom_range(0, 1) == 1);
            upd_done_B = ($urandom_range(0, 1) == 1);
            n_checks++;
            if ({rd_issue, rew_valid_A, rew_valid_B, busy, episode_done} !== 5'd0) begin
                n_fail++; $display("FAIL quiet_after_reset i=%0d got iss=%b rew=%b%b busy=%b ed=%b want 0",
                    i, rd_issue, rew_valid_A, rew_valid_B, busy, episode_done);
            end
        end
        idle_inputs();
        begin_episode();
        run_step(1, 0, 0, 1, 1'b0, 1'b0, 1'b0, e);
        run_step(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, e);
        check_episode_end();
    endtask

    task automatic test_random();
        bit e;
        for (int ep = 0; ep < 6; ep++) begin
            begin_episode();
            e = 1'b0;
            while (!e) begin
                run_step($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                         $urandom_range(0, 4), ($urandom_range(0, 3) == 0),
                         ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), e);
            end
            check_episode_end();
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_staggered();
        test_reward_order();
        test_terminal();
        test_term_and_limit();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
